// File: rtl/segscan_decoder.sv
// Scan-bus monitor: rebuilds the four multiplexed 7-segment digits from seg/segen.
// Optional scan-order checking is enabled by defining SEGSCAN_SEQ_CHECK_EN.
module segscan_decoder #(
    parameter int unsigned STABLE_CYCLES = 1,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic       clk10,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] segen,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit_ok,
    output logic [3:0] stale,
    output logic       frame_valid,
    output logic       seq_err
);
    localparam logic [3:0]  STABLE_N  = 4'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT);

    logic [6:0]  s_seg, p_seg;
    logic [3:0]  s_en, p_en;
    logic [3:0]  stab_cnt, stab_nxt;
    logic        legal, same, capture, seq_bad;
    logic [1:0]  idx;
    logic [3:0]  onehot;
    logic [3:0]  dec_val;
    logic        dec_ok;
    logic [6:0]  seg_r [4];
    logic [3:0]  dig_r [4];
    logic [3:0]  ok_r, seen, seen_nxt;
    logic        fv_nxt;
    logic [15:0] stc [4];

    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        case (s_en)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    assign onehot = 4'b0001 << idx;
    assign same   = ({s_en, s_seg} == {p_en, p_seg});

    // Capture exactly when the run length first equals STABLE_CYCLES.
    always_comb begin
        stab_nxt = '0;
        capture  = 1'b0;
        if (legal) begin
            if (same)
                stab_nxt = (stab_cnt == STABLE_N) ? STABLE_N : stab_cnt + 4'd1;
            else
                stab_nxt = 4'd1;
            capture = (stab_nxt == STABLE_N) && !(same && stab_cnt == STABLE_N);
        end
    end

    always_comb begin
        dec_ok = 1'b1;
        case (s_seg)
            7'h40: dec_val = 4'h0;
            7'h79: dec_val = 4'h1;
            7'h24: dec_val = 4'h2;
            7'h30: dec_val = 4'h3;
            7'h19: dec_val = 4'h4;
            7'h12: dec_val = 4'h5;
            7'h02: dec_val = 4'h6;
            7'h78: dec_val = 4'h7;
            7'h00: dec_val = 4'h8;
            7'h10: dec_val = 4'h9;
            7'h08: dec_val = 4'hA;
            7'h03: dec_val = 4'hB;
            7'h46: dec_val = 4'hC;
            7'h21: dec_val = 4'hD;
            7'h06: dec_val = 4'hE;
            7'h0E: dec_val = 4'hF;
            default: begin
                dec_val = 4'h0;
                dec_ok  = 1'b0;
            end
        endcase
    end

`ifdef SEGSCAN_SEQ_CHECK_EN
    logic       first;
    logic [1:0] prev_idx;

    assign seq_bad = capture && !first && (idx != prev_idx + 2'd1);

    always_ff @(posedge clk10 or negedge rst_n) begin
        if (!rst_n) begin
            first    <= 1'b1;
            prev_idx <= 2'd0;
            seq_err  <= 1'b0;
        end else if (capture) begin
            first    <= 1'b0;
            prev_idx <= idx;
            if (seq_bad)
                seq_err <= 1'b1;
        end
    end
`else
    assign seq_bad = 1'b0;
    assign seq_err = 1'b0;
`endif

    // An out-of-order capture restarts the frame at the violating slot.
    always_comb begin
        seen_nxt = seen;
        fv_nxt   = 1'b0;
        if (capture) begin
            seen_nxt = seq_bad ? onehot : (seen | onehot);
            if (seen_nxt == 4'hF) begin
                fv_nxt   = 1'b1;
                seen_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk10 or negedge rst_n) begin
        if (!rst_n) begin
            s_seg       <= '1;
            s_en        <= '1;
            p_seg       <= '1;
            p_en        <= '1;
            stab_cnt    <= '0;
            seen        <= '0;
            ok_r        <= '0;
            frame_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                seg_r[i] <= '1;
                dig_r[i] <= '0;
                stc[i]   <= TIMEOUT_N;
            end
        end else begin
            s_seg       <= seg;
            s_en        <= segen;
            p_seg       <= s_seg;
            p_en        <= s_en;
            stab_cnt    <= stab_nxt;
            seen        <= seen_nxt;
            frame_valid <= fv_nxt;
            if (capture) begin
                seg_r[idx] <= s_seg;
                dig_r[idx] <= dec_val;
                ok_r[idx]  <= dec_ok;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                if (capture && idx == 2'(i))
                    stc[i] <= '0;
                else if (stc[i] != TIMEOUT_N)
                    stc[i] <= stc[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stale = '0;
        for (int unsigned i = 0; i < 4; i++)
            stale[i] = (stc[i] == TIMEOUT_N);
    end

    assign seg1     = seg_r[0];
    assign seg2     = seg_r[1];
    assign seg3     = seg_r[2];
    assign seg4     = seg_r[3];
    assign digit1   = dig_r[0];
    assign digit2   = dig_r[1];
    assign digit3   = dig_r[2];
    assign digit4   = dig_r[3];
    assign digit_ok = ok_r;
endmodule

// File: tb/tb_segscan_decoder.sv
// Bench for segscan_decoder: two instances (STABLE 1/TIMEOUT 8 and STABLE 3/TIMEOUT 64)
// on one bus, checked against a history-based reference model plus directed sequences.
module tb_segscan_decoder;
    logic       clk10 = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg   = '1;
    logic [3:0] segen = '1;

    logic [1:0][3:0][6:0] oseg;
    logic [1:0][3:0][3:0] odig;
    logic [1:0][3:0]      ook, ostale;
    logic [1:0]           ofv, oerr;

    int tests  = 0;
    int failed = 0;
    int fv0    = 0;

    always #5 clk10 = ~clk10;

    segscan_decoder #(.STABLE_CYCLES(1), .TIMEOUT(8)) dut0 (
        .clk10(clk10), .rst_n(rst_n), .seg(seg), .segen(segen),
        .seg1(oseg[0][0]), .seg2(oseg[0][1]), .seg3(oseg[0][2]), .seg4(oseg[0][3]),
        .digit1(odig[0][0]), .digit2(odig[0][1]), .digit3(odig[0][2]), .digit4(odig[0][3]),
        .digit_ok(ook[0]), .stale(ostale[0]), .frame_valid(ofv[0]), .seq_err(oerr[0]));

    segscan_decoder #(.STABLE_CYCLES(3), .TIMEOUT(64)) dut1 (
        .clk10(clk10), .rst_n(rst_n), .seg(seg), .segen(segen),
        .seg1(oseg[1][0]), .seg2(oseg[1][1]), .seg3(oseg[1][2]), .seg4(oseg[1][3]),
        .digit1(odig[1][0]), .digit2(odig[1][1]), .digit3(odig[1][2]), .digit4(odig[1][3]),
        .digit_ok(ook[1]), .stale(ostale[1]), .frame_valid(ofv[1]), .seq_err(oerr[1]));

    // Reference model: decisions taken from the sampled-bus history.
    logic [6:0]  pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [10:0] hist [2][16];
    logic [6:0]  mseg [2][4];
    logic [3:0]  mdig [2][4];
    logic [3:0]  mok [2];
    logic [3:0]  mseen [2];
    int          mstc [2][4];
    logic        mfv [2], merr [2], mfirst [2];
    int          mprev [2];

    localparam logic [53:0] RST_PACK = {28'hFFFFFFF, 16'h0, 4'h0, 4'hF, 2'b00};

    function automatic int sc(input int m);
        return (m == 0) ? 1 : 3;
    endfunction

    function automatic int tmo(input int m);
        return (m == 0) ? 8 : 64;
    endfunction

    function automatic logic [3:0] en_of(input int i);
        logic [3:0] t;
        t = 4'b0001 << i;
        return ~t;
    endfunction

    function automatic int slot_of(input logic [3:0] en);
        for (int i = 0; i < 4; i++)
            if (en == en_of(i)) return i;
        return -1;
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 16; j++) hist[m][j] = '1;
            for (int i = 0; i < 4; i++) begin
                mseg[m][i] = '1;
                mdig[m][i] = '0;
                mstc[m][i] = tmo(m);
            end
            mok[m] = '0; mseen[m] = '0; mfv[m] = 1'b0; merr[m] = 1'b0;
            mfirst[m] = 1'b1; mprev[m] = 0;
        end
    endtask

    task automatic mstep(input int m);
        logic [10:0] v;
        int sl;
        bit cap;
        v   = hist[m][0];
        sl  = slot_of(v[10:7]);
        cap = (sl >= 0);
        for (int j = 0; j < sc(m); j++)
            if (hist[m][j] != v) cap = 0;
        if (hist[m][sc(m)] == v) cap = 0;
        mfv[m] = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!(cap && sl == i) && mstc[m][i] < tmo(m)) mstc[m][i]++;
        if (cap) begin
            mseg[m][sl] = v[6:0];
            mdig[m][sl] = '0;
            mok[m][sl]  = 1'b0;
            for (int d = 0; d < 16; d++)
                if (pats[d] == v[6:0]) begin
                    mdig[m][sl] = 4'(d);
                    mok[m][sl]  = 1'b1;
                end
            mstc[m][sl] = 0;
`ifdef SEGSCAN_SEQ_CHECK_EN
            if (!mfirst[m] && sl != (mprev[m] + 1) % 4) begin
                merr[m]  = 1'b1;
                mseen[m] = '0;
            end
            mfirst[m] = 1'b0;
            mprev[m]  = sl;
`endif
            mseen[m][sl] = 1'b1;
            if (mseen[m] == 4'hF) begin
                mfv[m]   = 1'b1;
                mseen[m] = '0;
            end
        end
        for (int j = 15; j > 0; j--) hist[m][j] = hist[m][j-1];
        hist[m][0] = {segen, seg};
    endtask

    always @(posedge clk10 or negedge rst_n) begin
        if (!rst_n) mreset();
        else begin
            mstep(0);
            mstep(1);
        end
    end

    function automatic logic [53:0] pack_act(input int m);
        return {oseg[m], odig[m], ook[m], ostale[m], ofv[m], oerr[m]};
    endfunction

    function automatic logic [53:0] pack_mod(input int m);
        logic [3:0] st;
        for (int i = 0; i < 4; i++) st[i] = (mstc[m][i] == tmo(m));
        return {mseg[m][3], mseg[m][2], mseg[m][1], mseg[m][0],
                mdig[m][3], mdig[m][2], mdig[m][1], mdig[m][0],
                mok[m], st, mfv[m], merr[m]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] p, input int n);
        for (int k = 0; k < n; k++) begin
            segen = en;
            seg   = p;
            @(negedge clk10);
            if (ofv[0]) fv0++;
            chk("model_m0", 64'(pack_act(0)), 64'(pack_mod(0)));
            chk("model_m1", 64'(pack_act(1)), 64'(pack_mod(1)));
        end
    endtask

    // Called at a negedge; asserts reset off-edge and releases at the next negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_m0", 64'(pack_act(0)), 64'(RST_PACK));
        chk("reset_m1", 64'(pack_act(1)), 64'(RST_PACK));
        segen = '1;
        seg   = '1;
        @(negedge clk10);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [6:0] pat;
        logic [3:0] dig;
        logic       ok;
    } vec_t;

    vec_t       tbl [18];
    logic [6:0] spat [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
    int         order [8] = '{0, 1, 3, 2, 0, 1, 2, 3};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs;
        logic [3:0] en;
        logic [6:0] p;
        tbl = '{'{7'h40, 4'h0, 1'b1}, '{7'h79, 4'h1, 1'b1}, '{7'h24, 4'h2, 1'b1},
                '{7'h30, 4'h3, 1'b1}, '{7'h19, 4'h4, 1'b1}, '{7'h12, 4'h5, 1'b1},
                '{7'h02, 4'h6, 1'b1}, '{7'h78, 4'h7, 1'b1}, '{7'h00, 4'h8, 1'b1},
                '{7'h10, 4'h9, 1'b1}, '{7'h08, 4'hA, 1'b1}, '{7'h03, 4'hB, 1'b1},
                '{7'h46, 4'hC, 1'b1}, '{7'h21, 4'hD, 1'b1}, '{7'h06, 4'hE, 1'b1},
                '{7'h0E, 4'hF, 1'b1}, '{7'h7F, 4'h0, 1'b0}, '{7'h55, 4'h0, 1'b0}};
        mreset();
        @(negedge clk10);
        do_reset();

        // Decode table on slot 1 of the single-cycle instance.
        for (int i = 0; i < 18; i++) begin
            drive(4'b1110, tbl[i].pat, 1);
            drive(4'b1111, 7'h7F, 1);
            chk($sformatf("decode_%0h", tbl[i].pat),
                64'({oseg[0][0], odig[0][0], ook[0][0]}),
                64'({tbl[i].pat, tbl[i].dig, tbl[i].ok}));
        end

        // Normal rotating scan: a frame every four captures.
        @(negedge clk10);
        do_reset();
        fv0 = 0;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) drive(en_of(i), spat[i], 1);
        drive(4'b1111, 7'h7F, 2);
        chk("scan_frames", 64'(fv0), 64'd3);
        chk("scan_digits", 64'(odig[0]), 64'h4321);
        chk("scan_ok_stale", 64'({ook[0], ostale[0]}), 64'hF0);

        // Stability filter on the STABLE_CYCLES=3 instance.
        do_reset();
        drive(4'b1101, 7'h12, 2);
        drive(4'b1111, 7'h7F, 4);
        chk("stab_short", 64'({oseg[1][1], odig[1][1], ook[1][1]}), 64'({7'h7F, 4'h0, 1'b0}));
        drive(4'b1101, 7'h12, 5);
        drive(4'b1111, 7'h7F, 4);
        chk("stab_long", 64'({oseg[1][1], odig[1][1], ook[1][1], oerr[1]}),
            64'({7'h12, 4'h5, 1'b1, 1'b0}));

        // Illegal enables and unknown pattern.
        do_reset();
        drive(4'b1111, 7'h79, 3);
        drive(4'b1001, 7'h79, 3);
        drive(4'b0000, 7'h24, 3);
        chk("illegal_en", 64'({oseg[0], ook[0]}), 64'({28'hFFFFFFF, 4'h0}));
        drive(4'b1110, 7'h40, 2);
        chk("legal_zero", 64'({oseg[0][0], odig[0][0], ook[0][0]}), 64'({7'h40, 4'h0, 1'b1}));
        drive(4'b1110, 7'h7F, 2);
        chk("unknown_pat", 64'({oseg[0][0], odig[0][0], ook[0][0]}), 64'({7'h7F, 4'h0, 1'b0}));

        // Staleness: slot 4 never scanned, then captured.
        do_reset();
        for (int k = 0; k < 21; k++) drive(en_of(k % 3), spat[k % 3], 1);
        chk("stale_slot4", 64'(ostale[0]), 64'h8);
        drive(4'b0111, 7'h19, 1);
        chk("stale_pre_cap", 64'(ostale[0][3]), 64'd1);
        drive(4'b1111, 7'h7F, 1);
        chk("stale_cleared", 64'(ostale[0]), 64'h0);

        // Scan order 0,1,3,2,0,1,2,3.
        do_reset();
        fv0 = 0;
        for (int k = 0; k < 8; k++) begin
            drive(en_of(order[k]), spat[order[k]], 1);
            if (k == 3) begin
`ifdef SEGSCAN_SEQ_CHECK_EN
                chk("seq_err_set", 64'(oerr[0]), 64'd1);
`else
                chk("seq_err_set", 64'(oerr[0]), 64'd0);
`endif
            end
        end
        drive(4'b1111, 7'h7F, 2);
`ifdef SEGSCAN_SEQ_CHECK_EN
        chk("seq_frames", 64'({fv0[3:0], 3'b0, oerr[0]}), 64'h11);
`else
        chk("seq_frames", 64'({fv0[3:0], 3'b0, oerr[0]}), 64'h20);
`endif

        // Randomized traffic against the model, with occasional mid-run resets.
        do_reset();
        rs = 0;
        for (int it = 0; it < 1500; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                rs = ($urandom_range(0, 1) == 1) ? (rs + 1) % 4 : int'($urandom_range(0, 3));
                en = en_of(rs);
            end else if (r == 7) en = 4'b1111;
            else en = 4'($urandom);
            if ($urandom_range(0, 4) == 0) p = 7'($urandom);
            else p = pats[$urandom_range(0, 15)];
            drive(en, p, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
